// File: rtl/touch_i2c_target.sv
// touch_i2c_target: I2C target (pointer-then-data protocol) with an NREGS x 8 register file also visible on an Avalon-MM port.
// Define TOUCH_I2C_IRQ_EN to add the irq output, which flags completed I2C write transactions.
module touch_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h38,
    parameter int         NREGS       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     scl_in,
    input  logic                     sda_in,
    output logic                     sda_oe,
    input  logic [$clog2(NREGS)-1:0] address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [7:0]               writedata,
    output logic [7:0]               readdata
`ifdef TOUCH_I2C_IRQ_EN
    ,
    output logic                     irq
`endif
);
    localparam int PW = $clog2(NREGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [7:0]             shift;
    logic [3:0]             bit_cnt;
    logic [PW-1:0]          ptr;
    logic [7:0]             regs [NREGS];
    logic                   cpu_we;
    logic                   wr_commit;

    // Input synchronizers plus previous-value flops; these track the pins continuously.
    always_ff @(posedge clk) begin
        scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
        sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        scl_prev <= scl_s;
        sda_prev <= sda_s;
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    assign cpu_we    = chipselect & ~write_n;
    assign wr_commit = (state == WR_DATA) && scl_fall && (bit_cnt == 4'd8);

    // Protocol FSM; sda_oe only moves on the cycle after a detected SCL fall (or on START/STOP).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            ptr     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (start_det) begin
            state   <= ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
        end else if (stop_det) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
        end else begin
            case (state)
                ADDR, WR_PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shift   <= {shift[6:0], sda_s};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= '0;
                        if (state == ADDR && shift[7:1] != DEV_ADDR) begin
                            state <= IGNORE;
                        end else begin
                            sda_oe <= 1'b1;
                            state  <= (state == ADDR) ? ADDR_ACK : WR_ACK;
                            if (state == WR_PTR)  ptr <= shift[PW-1:0];
                            if (state == WR_DATA) ptr <= ptr + 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt <= '0;
                        if (shift[0]) begin
                            shift  <= regs[ptr];
                            sda_oe <= ~regs[ptr][7];
                            state  <= RD_DATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= WR_PTR;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= RD_ACK;
                        end else begin
                            shift  <= {shift[6:0], 1'b0};
                            sda_oe <= ~shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    // bit_cnt == 1 marks that the master ACKed and the next byte is due on the fall.
                    if (scl_rise) begin
                        if (sda_s) begin
                            state <= IGNORE;
                        end else begin
                            ptr     <= ptr + 1'b1;
                            bit_cnt <= 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        shift   <= regs[ptr];
                        sda_oe  <= ~regs[ptr][7];
                        bit_cnt <= '0;
                        state   <= RD_DATA;
                    end
                end
                default: sda_oe <= 1'b0;
            endcase
        end
    end

    // Register file: the I2C write is applied last so it wins a same-cycle collision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            readdata <= '0;
        end else begin
            readdata <= regs[address];
            if (cpu_we)    regs[address] <= writedata;
            if (wr_commit) regs[ptr]     <= shift;
        end
    end

`ifdef TOUCH_I2C_IRQ_EN
    logic wr_seen;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_seen <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (stop_det)       wr_seen <= 1'b0;
            else if (wr_commit) wr_seen <= 1'b1;
            if (stop_det && wr_seen) irq <= 1'b1;
            else if (cpu_we)         irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_touch_i2c_target.sv
// Directed bench for touch_i2c_target: bit-level I2C master on an open-drain SDA plus Avalon CPU accesses.
module tb_touch_i2c_target;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [3:0] address = '0;
    logic       chipselect = 1'b0;
    logic       write_n = 1'b1;
    logic [7:0] writedata = '0;
    logic [7:0] readdata;
`ifdef TOUCH_I2C_IRQ_EN
    logic       irq;
`endif
    logic       oe_seen = 1'b0;
    int         checks = 0;
    int         errors = 0;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    always @(negedge clk) if (sda_oe === 1'b1) oe_seen = 1'b1;

    touch_i2c_target dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata)
`ifdef TOUCH_I2C_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic i2c_write(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_q();
            scl_m = 1'b1; wait_q();
            scl_m = 1'b0; wait_q();
        end
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; repeat (Q/2) @(negedge clk);
        ack = sda_oe; repeat (Q/2) @(negedge clk);
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_read(input logic nack, output logic [7:0] b, output logic oe_at_ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_q();
            scl_m = 1'b1; repeat (Q/2) @(negedge clk);
            b[i] = sda_in; repeat (Q/2) @(negedge clk);
            scl_m = 1'b0; wait_q();
        end
        sda_m = nack; wait_q();
        scl_m = 1'b1; repeat (Q/2) @(negedge clk);
        oe_at_ack = sda_oe; repeat (Q/2) @(negedge clk);
        scl_m = 1'b0; wait_q();
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        checks++;
        if (readdata !== 8'h00) begin errors++; $display("FAIL reset_readdata: got %h want 00", readdata); end
`ifdef TOUCH_I2C_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        logic [7:0] d;
        i2c_start();
        i2c_write(8'h70, a0);
        i2c_write(8'h02, a1);
        i2c_write(8'hA5, a2);
        i2c_stop();
        checks++;
        if (a0 !== 1'b1) begin errors++; $display("FAIL write_addr_ack: got %b want 1", a0); end
        checks++;
        if (a1 !== 1'b1) begin errors++; $display("FAIL write_ptr_ack: got %b want 1", a1); end
        checks++;
        if (a2 !== 1'b1) begin errors++; $display("FAIL write_data_ack: got %b want 1", a2); end
        cpu_read(4'd2, d);
        checks++;
        if (d !== 8'hA5) begin errors++; $display("FAIL write_readback: got %h want a5", d); end
    endtask

    task automatic test_ptr_persist();
        logic a0, oe;
        logic [7:0] b;
        cpu_write(4'd3, 8'h3C);
        i2c_start();
        i2c_write(8'h71, a0);
        i2c_read(1'b1, b, oe);
        i2c_stop();
        checks++;
        if (a0 !== 1'b1) begin errors++; $display("FAIL persist_addr_ack: got %b want 1", a0); end
        checks++;
        if (b !== 8'h3C) begin errors++; $display("FAIL persist_data: got %h want 3c", b); end
        checks++;
        if (oe !== 1'b0) begin errors++; $display("FAIL persist_nack_oe: got %b want 0", oe); end
    endtask

    task automatic test_read();
        logic a0, a1, a2, oe;
        logic [7:0] b;
        cpu_write(4'd3, 8'h5C);
        i2c_start();
        i2c_write(8'h70, a0);
        i2c_write(8'h03, a1);
        i2c_start();
        i2c_write(8'h71, a2);
        i2c_read(1'b1, b, oe);
        i2c_stop();
        checks++;
        if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
        checks++;
        if (b !== 8'h5C) begin errors++; $display("FAIL read_data: got %h want 5c", b); end
        checks++;
        if (oe !== 1'b0) begin errors++; $display("FAIL read_nack_oe: got %b want 0", oe); end
        checks++;
        if (sda_oe !== 1'b0) begin errors++; $display("FAIL read_after_stop_oe: got %b want 0", sda_oe); end
    endtask

    task automatic test_read_burst();
        logic a0, a1, a2, oe0, oe1;
        logic [7:0] b0, b1;
        cpu_write(4'd5, 8'hA1);
        cpu_write(4'd6, 8'h3E);
        i2c_start();
        i2c_write(8'h70, a0);
        i2c_write(8'h05, a1);
        i2c_start();
        i2c_write(8'h71, a2);
        i2c_read(1'b0, b0, oe0);
        i2c_read(1'b1, b1, oe1);
        i2c_stop();
        checks++;
        if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL burst_acks: got %b want 111", {a0, a1, a2}); end
        checks++;
        if (b0 !== 8'hA1) begin errors++; $display("FAIL burst_byte0: got %h want a1", b0); end
        checks++;
        if (b1 !== 8'h3E) begin errors++; $display("FAIL burst_byte1: got %h want 3e", b1); end
        checks++;
        if ({oe0, oe1} !== 2'b00) begin errors++; $display("FAIL burst_master_ack_oe: got %b want 00", {oe0, oe1}); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3, oe;
        logic [7:0] d;
        i2c_start();
        i2c_write(8'h70, a0);
        i2c_write(8'h0F, a1);
        i2c_write(8'h11, a2);
        i2c_write(8'h22, a3);
        i2c_stop();
        checks++;
        if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL wrap_acks: got %b want 1111", {a0, a1, a2, a3}); end
        cpu_read(4'd15, d);
        checks++;
        if (d !== 8'h11) begin errors++; $display("FAIL wrap_reg15: got %h want 11", d); end
        cpu_read(4'd0, d);
        checks++;
        if (d !== 8'h22) begin errors++; $display("FAIL wrap_reg0: got %h want 22", d); end
        cpu_write(4'd1, 8'h77);
        i2c_start();
        i2c_write(8'h71, a0);
        i2c_read(1'b1, d, oe);
        i2c_stop();
        checks++;
        if ({a0, oe} !== 2'b10) begin errors++; $display("FAIL wrap_read_handshake: got %b want 10", {a0, oe}); end
        checks++;
        if (d !== 8'h77) begin errors++; $display("FAIL wrap_ptr_is_1: got %h want 77", d); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        logic [7:0] d;
        oe_seen = 1'b0;
        i2c_start();
        i2c_write(8'h72, a0);
        i2c_write(8'h00, a1);
        i2c_stop();
        checks++;
        if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL wrong_addr_acks: got %b want 00", {a0, a1}); end
        checks++;
        if (oe_seen !== 1'b0) begin errors++; $display("FAIL wrong_addr_oe_seen: got %b want 0", oe_seen); end
        cpu_read(4'd0, d);
        checks++;
        if (d !== 8'h22) begin errors++; $display("FAIL wrong_addr_reg0: got %h want 22", d); end
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2;
        logic [7:0] d;
        cpu_write(4'd4, 8'h00);
        i2c_start();
        i2c_write(8'h70, a0);
        i2c_write(8'h04, a1);
        i2c_start();
        i2c_write(8'h71, a2);
        checks++;
        if ({a0, a1, a2, sda_oe} !== 4'b1111) begin
            errors++; $display("FAIL midrd_setup: got %b want 1111", {a0, a1, a2, sda_oe});
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sda_oe !== 1'b0) begin errors++; $display("FAIL midrd_release: got %b want 0", sda_oe); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cpu_read(4'(i), d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL midrd_reg%0d: got %h want 00", i, d); end
        end
        i2c_start();
        i2c_write(8'h70, a0);
        i2c_stop();
        checks++;
        if (a0 !== 1'b1) begin errors++; $display("FAIL midrd_fresh_ack: got %b want 1", a0); end
    endtask

`ifdef TOUCH_I2C_IRQ_EN
    task automatic test_irq();
        logic a0, a1, a2, oe;
        logic [7:0] b;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
        i2c_start();
        i2c_write(8'h70, a0);
        i2c_write(8'h08, a1);
        i2c_write(8'h99, a2);
        i2c_stop();
        checks++;
        if ({a0, a1, a2, irq} !== 4'b1111) begin errors++; $display("FAIL irq_set: got %b want 1111", {a0, a1, a2, irq}); end
        cpu_write(4'd9, 8'h00);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
        i2c_start();
        i2c_write(8'h71, a0);
        i2c_read(1'b1, b, oe);
        i2c_stop();
        checks++;
        if ({a0, oe, b, irq} !== {2'b10, 8'h00, 1'b0}) begin
            errors++; $display("FAIL irq_read_only: got %b/%h/%b want 10/00/0", {a0, oe}, b, irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_ptr_persist();
        test_read();
        test_read_burst();
        test_wrap();
        test_wrong_addr();
        test_reset_mid_read();
`ifdef TOUCH_I2C_IRQ_EN
        test_irq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
